// File: rtl/draw_job_scheduler.sv
// draw_job_scheduler
//
// Arbitrates rectangular pixel-write jobs from NREQ rasterizer requesters
// (round-robin). It sequences the framebuffer burst writer for each granted job
// and generates per-pixel coordinates. It also owns front/back framebuffer
// selection, swapping the two buffers on vsync.
//
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   req_valid/ready       job handshake per requester (ready is a 1-cycle pulse)
//   req_x/y/w/h           job origin and (columns-1, rows-1), 11 bits each
//   req_pixel_*           per-requester pixel stream (data, draw, valid, ready)
//   req_done              1-cycle job-complete pulse per requester
//   wr_baseaddr           back-buffer base address to the writer
//   wr_pixel_x/y          coordinate of the current pixel
//   wr_start              1-cycle job-start pulse to the writer
//   wr_width/height       latched job size
//   wr_pixel_*            muxed pixel stream to the writer
//   wr_state              writer state, 0 = idle
//   vsync, swap_req       frame sync and buffer-swap request
//   display_baseaddr      front-buffer base address
//   swap_done             1-cycle pulse when a swap takes effect
//   busy, grant_id        scheduler busy flag and granted requester index
module draw_job_scheduler #(
   parameter int          NREQ     = 2,
   parameter logic [31:0] FB_BASE0 = 32'h1000_0000,
   parameter logic [31:0] FB_BASE1 = 32'h1010_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [11*NREQ-1:0]  req_x,
   input  logic [11*NREQ-1:0]  req_y,
   input  logic [11*NREQ-1:0]  req_w,
   input  logic [11*NREQ-1:0]  req_h,
   output logic [NREQ-1:0]     req_ready,
   input  logic [8*NREQ-1:0]   req_pixel_data,
   input  logic [NREQ-1:0]     req_draw,
   input  logic [NREQ-1:0]     req_pixel_valid,
   output logic [NREQ-1:0]     req_pixel_ready,
   output logic [NREQ-1:0]     req_done,
   output logic [31:0]         wr_baseaddr,
   output logic [10:0]         wr_pixel_x,
   output logic [10:0]         wr_pixel_y,
   output logic                wr_start,
   output logic [10:0]         wr_width,
   output logic [10:0]         wr_height,
   output logic [7:0]          wr_pixel_data,
   output logic                wr_draw,
   output logic                wr_pixel_valid,
   input  logic                wr_pixel_ready,
   input  logic [3:0]          wr_state,
   input  logic                vsync,
   input  logic                swap_req,
   output logic [31:0]         display_baseaddr,
   output logic                swap_done,
   output logic                busy,
   output logic [1:0]          grant_id
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_DRAIN, S_DONE} state_t;

   state_t      state;
   logic [1:0]  last;
   logic [10:0] x0;
   logic [10:0] y0;
   // One bit wider than the 22 bits the geometry suggests: a full
   // 2048 x 2048 job holds 2^22 pixels, which would wrap a 22-bit counter.
   logic [22:0] remaining;
   logic [1:0]  drain_cnt;
   logic        vsync_p1;
   logic        swap_pend;

   logic [1:0]      winner;
   logic            any_req;
   logic            grant;
   logic            swap_fire;
   logic            streaming;
   logic            xfer;
   logic            drain_exit;
   logic [NREQ-1:0] gid_oh;
   logic [10:0]     sel_x, sel_y, sel_w, sel_h;
   logic [10:0]     x_end;
   logic [22:0]     cols, rows;

   // Round-robin pick: smallest distance from last+1 (mod NREQ) wins.
   function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] v, input logic [1:0] lst);
      logic [1:0] pick;
      int         best_d;
      int         d;
      pick   = '0;
      best_d = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         d = (i + NREQ - 1 - int'(lst)) % NREQ;
         if (v[i] && d < best_d) begin
            best_d = d;
            pick   = 2'(i);
         end
      end
      return pick;
   endfunction

   assign any_req    = |req_valid;
   assign winner     = rr_pick(req_valid, last);
   assign grant      = (state == S_IDLE) && any_req;
   // A swap only takes an idle cycle that no requester wants.
   assign swap_fire  = (state == S_IDLE) && !any_req && swap_pend && vsync && !vsync_p1;
   assign streaming  = (state == S_STREAM);
   assign xfer       = wr_pixel_valid && wr_pixel_ready;
   assign drain_exit = (state == S_DRAIN) && (drain_cnt == 2'd2) && (wr_state == 4'd0);
   assign x_end      = x0 + wr_width;
   assign cols       = {12'd0, wr_width} + 23'd1;
   assign rows       = {12'd0, wr_height} + 23'd1;

   always_comb begin
      req_ready       = '0;
      req_pixel_ready = '0;
      gid_oh          = '0;
      wr_pixel_valid  = 1'b0;
      wr_draw         = 1'b0;
      wr_pixel_data   = '0;
      sel_x           = '0;
      sel_y           = '0;
      sel_w           = '0;
      sel_h           = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant && (winner == 2'(i));
         if (winner == 2'(i)) begin
            sel_x = req_x[11*i +: 11];
            sel_y = req_y[11*i +: 11];
            sel_w = req_w[11*i +: 11];
            sel_h = req_h[11*i +: 11];
         end
         if (grant_id == 2'(i)) begin
            gid_oh[i]          = 1'b1;
            req_pixel_ready[i] = streaming && wr_pixel_ready;
            wr_pixel_valid     = streaming && req_pixel_valid[i];
            wr_draw            = streaming && req_draw[i];
            wr_pixel_data      = req_pixel_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         last             <= 2'(NREQ - 1);
         x0               <= '0;
         y0               <= '0;
         remaining        <= '0;
         drain_cnt        <= '0;
         vsync_p1         <= 1'b0;
         swap_pend        <= 1'b0;
         swap_done        <= 1'b0;
         display_baseaddr <= FB_BASE0;
         wr_baseaddr      <= FB_BASE1;
         wr_pixel_x       <= '0;
         wr_pixel_y       <= '0;
         wr_width         <= '0;
         wr_height        <= '0;
         wr_start         <= 1'b0;
         req_done         <= '0;
         busy             <= 1'b0;
         grant_id         <= '0;
      end else begin
         wr_start  <= 1'b0;
         req_done  <= drain_exit ? gid_oh : '0;
         swap_done <= swap_fire;
         vsync_p1  <= vsync;

         if (swap_fire) begin
            display_baseaddr <= wr_baseaddr;
            wr_baseaddr      <= display_baseaddr;
            swap_pend        <= 1'b0;
         end else if (swap_req) begin
            swap_pend <= 1'b1;
         end

         case (state)
            // Grant: latch geometry and present the origin during START.
            S_IDLE: begin
               if (grant) begin
                  grant_id   <= winner;
                  x0         <= sel_x;
                  y0         <= sel_y;
                  wr_width   <= sel_w;
                  wr_height  <= sel_h;
                  wr_pixel_x <= sel_x;
                  wr_pixel_y <= sel_y;
                  wr_start   <= 1'b1;
                  busy       <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               remaining <= cols * rows;
               drain_cnt <= '0;
               state     <= S_STREAM;
            end
            // Raster walk: x runs x0..x0+w, then wraps and y advances.
            S_STREAM: begin
               if (xfer) begin
                  remaining <= remaining - 23'd1;
                  if (wr_pixel_x == x_end) begin
                     wr_pixel_x <= x0;
                     wr_pixel_y <= wr_pixel_y + 11'd1;
                  end else begin
                     wr_pixel_x <= wr_pixel_x + 11'd1;
                  end
                  if (remaining == 23'd1) state <= S_DRAIN;
               end
            end
            // Give the writer two cycles to leave idle before trusting wr_state.
            S_DRAIN: begin
               if (drain_cnt != 2'd2) drain_cnt <= drain_cnt + 2'd1;
               else if (drain_exit)   state     <= S_DONE;
            end
            S_DONE: begin
               last  <= grant_id;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_draw_job_scheduler.sv
// Directed testbench for draw_job_scheduler (NREQ = 2).
module tb_draw_job_scheduler;

   localparam int          NREQ = 2;
   localparam logic [31:0] B0   = 32'h1000_0000;
   localparam logic [31:0] B1   = 32'h1010_0000;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [11*NREQ-1:0]  req_x, req_y, req_w, req_h;
   logic [NREQ-1:0]     req_ready;
   logic [8*NREQ-1:0]   req_pixel_data;
   logic [NREQ-1:0]     req_draw;
   logic [NREQ-1:0]     req_pixel_valid;
   logic [NREQ-1:0]     req_pixel_ready;
   logic [NREQ-1:0]     req_done;
   logic [31:0]         wr_baseaddr;
   logic [10:0]         wr_pixel_x, wr_pixel_y;
   logic                wr_start;
   logic [10:0]         wr_width, wr_height;
   logic [7:0]          wr_pixel_data;
   logic                wr_draw;
   logic                wr_pixel_valid;
   logic                wr_pixel_ready;
   logic [3:0]          wr_state;
   logic                vsync;
   logic                swap_req;
   logic [31:0]         display_baseaddr;
   logic                swap_done;
   logic                busy;
   logic [1:0]          grant_id;

   int n_checks = 0;
   int n_fail   = 0;

   draw_job_scheduler #(.NREQ(NREQ), .FB_BASE0(B0), .FB_BASE1(B1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
      .req_ready(req_ready), .req_pixel_data(req_pixel_data), .req_draw(req_draw),
      .req_pixel_valid(req_pixel_valid), .req_pixel_ready(req_pixel_ready), .req_done(req_done),
      .wr_baseaddr(wr_baseaddr), .wr_pixel_x(wr_pixel_x), .wr_pixel_y(wr_pixel_y),
      .wr_start(wr_start), .wr_width(wr_width), .wr_height(wr_height),
      .wr_pixel_data(wr_pixel_data), .wr_draw(wr_draw), .wr_pixel_valid(wr_pixel_valid),
      .wr_pixel_ready(wr_pixel_ready), .wr_state(wr_state), .vsync(vsync), .swap_req(swap_req),
      .display_baseaddr(display_baseaddr), .swap_done(swap_done), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic set_geom(input int x, input int y, input int w, input int h);
      for (int i = 0; i < NREQ; i++) begin
         req_x[11*i +: 11] = 11'(x);
         req_y[11*i +: 11] = 11'(y);
         req_w[11*i +: 11] = 11'(w);
         req_h[11*i +: 11] = 11'(h);
      end
   endtask

   task automatic reset_checks(input string p);
      check({p, "_busy"},       busy, 0);
      check({p, "_grant_id"},   grant_id, 0);
      check({p, "_wr_start"},   wr_start, 0);
      check({p, "_pix_x"},      wr_pixel_x, 0);
      check({p, "_pix_y"},      wr_pixel_y, 0);
      check({p, "_width"},      wr_width, 0);
      check({p, "_height"},     wr_height, 0);
      check({p, "_pix_valid"},  wr_pixel_valid, 0);
      check({p, "_req_done"},   req_done, 0);
      check({p, "_pix_ready"},  req_pixel_ready, 0);
      check({p, "_swap_done"},  swap_done, 0);
      check({p, "_display"},    display_baseaddr, B0);
      check({p, "_wr_base"},    wr_baseaddr, B1);
   endtask

   // Runs one job for expected requester g. Requesters in vmask raise req_valid;
   // with hold set they keep it high through the job. vsync_at raises vsync at that
   // stream cycle. abort_after > 0 asserts reset after that many transfers.
   task automatic do_job(input int g, input int x, input int y, input int w, input int h,
                         input bit stall, input logic [NREQ-1:0] vmask, input bit hold,
                         input int vsync_at, input int abort_after);
      int ex, ey, cnt, total, lat;
      bit other_rdy, saw_swap, done_seen, early_done;
      total = (w + 1) * (h + 1);
      @(negedge clk);
      set_geom(x, y, w, h);
      req_valid = vmask;
      #1;
      check("req_ready", req_ready, oh(g));
      check("busy_idle", busy, 0);
      @(negedge clk);
      check("wr_start", wr_start, 1);
      check("grant_id", grant_id, g);
      check("busy_start", busy, 1);
      check("wr_width", wr_width, w);
      check("wr_height", wr_height, h);
      check("start_x", wr_pixel_x, x);
      check("start_y", wr_pixel_y, y);
      check("ready_one_cycle", req_ready, 0);
      if (!hold) req_valid = '0;
      wr_state  = 4'd1;
      ex        = x;
      ey        = y;
      cnt       = 0;
      other_rdy = 0;
      saw_swap  = 0;
      for (int c = 0; c < 20000 && cnt < total; c++) begin
         @(negedge clk);
         if (c == vsync_at) vsync = 1'b1;
         if (c == vsync_at + 3) vsync = 1'b0;
         wr_pixel_ready = (stall ? ($urandom_range(0, 2) != 0) : 1'b1) && wr_pixel_valid;
         #1;
         if (c == 0) check("first_fwd_valid", wr_pixel_valid, 1);
         if (swap_done) saw_swap = 1;
         if ((req_pixel_ready & ~oh(g)) != '0) other_rdy = 1;
         if (wr_pixel_valid && wr_pixel_ready) begin
            check("pix_x", wr_pixel_x, ex);
            check("pix_y", wr_pixel_y, ey);
            check("pix_data", wr_pixel_data, 8'hA0 + g);
            check("pix_rdy_g", req_pixel_ready, oh(g));
            cnt++;
            if (ex == x + w) begin
               ex = x;
               ey = (ey + 1) % 2048;
            end else begin
               ex = ex + 1;
            end
            if (abort_after > 0 && cnt == abort_after) begin
               @(posedge clk);
               #2;
               reset          = 1'b0;
               wr_pixel_ready = 1'b0;
               req_valid      = '0;
               wr_state       = 4'd0;
               #1;
               reset_checks("abort");
               early_done = 0;
               repeat (3) begin
                  @(negedge clk);
                  if (req_done != '0) early_done = 1;
               end
               check("abort_no_done", early_done, 0);
               reset = 1'b1;
               return;
            end
         end
      end
      check("xfer_count", cnt, total);
      check("other_pix_ready", other_rdy, 0);
      @(negedge clk);
      wr_pixel_ready = 1'b0;
      #1;
      check("drain_valid", wr_pixel_valid, 0);
      check("no_early_done", req_done, 0);
      wr_state  = 4'd0;
      lat       = 1;
      done_seen = 0;
      for (int c = 0; c < 50 && !done_seen; c++) begin
         @(negedge clk);
         lat++;
         if (swap_done) saw_swap = 1;
         if (req_done != '0) done_seen = 1;
      end
      check("done_seen", done_seen, 1);
      check("req_done", req_done, oh(g));
      check("done_latency_ge3", lat >= 3, 1);
      check("swap_in_job", saw_swap, 0);
      check("end_x", wr_pixel_x, x);
      check("end_y", wr_pixel_y, (y + h + 1) % 2048);
      check("hold_width", wr_width, w);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset           = 1'b0;
      req_valid       = '0;
      req_x           = '0;
      req_y           = '0;
      req_w           = '0;
      req_h           = '0;
      req_pixel_data  = {8'hA1, 8'hA0};
      req_draw        = '1;
      req_pixel_valid = '1;
      wr_pixel_ready  = 1'b0;
      wr_state        = 4'd0;
      vsync           = 1'b0;
      swap_req        = 1'b0;
      #12;
      reset_checks("rst");
      @(negedge clk);
      reset = 1'b1;

      // 1x1 job on requester 0 (last resets to NREQ-1, so 0 wins first).
      do_job(0, 5, 7, 0, 0, 0, 2'b01, 0, -1, 0);
      // 20x2 job on requester 1 with random writer stalls.
      do_job(1, 100, 10, 19, 1, 1, 2'b10, 0, -1, 0);
      // Round-robin: both held valid, grants 0, 1, 0.
      do_job(0, 3, 4, 2, 1, 0, 2'b11, 1, -1, 0);
      do_job(1, 3, 4, 2, 1, 0, 2'b11, 1, -1, 0);
      do_job(0, 3, 4, 2, 1, 0, 2'b11, 0, -1, 0);

      // Deferred swap: vsync during STREAM is ignored, the next idle vsync swaps.
      @(negedge clk);
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      check("swap_idle_no_vsync", swap_done, 0);
      do_job(1, 50, 60, 7, 0, 0, 2'b10, 0, 2, 0);
      check("swap_deferred_disp", display_baseaddr, B0);
      check("swap_deferred_wr", wr_baseaddr, B1);
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      check("swap_done_pulse", swap_done, 1);
      check("swap_disp", display_baseaddr, B1);
      check("swap_wr", wr_baseaddr, B0);
      vsync = 1'b0;
      @(negedge clk);
      check("swap_done_once", swap_done, 0);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      check("swap_pend_cleared", swap_done, 0);
      check("swap_disp_stable", display_baseaddr, B1);

      // Maximum width: 2048 pixels in one row, x wraps only after the last.
      do_job(0, 0, 20, 2047, 0, 0, 2'b01, 0, -1, 0);

      // Reset after 5 of 16 pixels, then a fresh job from its own origin.
      do_job(1, 30, 40, 15, 0, 0, 2'b10, 0, -1, 5);
      do_job(0, 200, 300, 3, 2, 1, 2'b11, 0, -1, 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
